// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter for a single-ported unified memory with 1-cycle read latency.
// Optional performance counters are compiled in with `define MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                if_stall,
  output logic                d_stall,
  output logic [15:0]         perf_if_stall,
  output logic [15:0]         perf_d_grant
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_LD = 2'd2
  } resp_state_e;

  resp_state_e            state_q, state_d;
  logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0]      if_rdata_q, d_rdata_q;

  // Grant selection: data wins unless fetch has waited STARVE_MAX data grants.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst) begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
    end else if (if_req && (starve_cnt_q == STARVE_LIM)) begin
      if_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end else if (if_req) begin
      if_gnt = 1'b1;
    end else begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
    end
    if_stall = if_req & ~if_gnt & ~rst;
    d_stall  = d_req & ~d_gnt & ~rst;
  end

  // Memory strobe for the winner of this cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = {BE_W{1'b0}};
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we ? d_be : {BE_W{1'b0}};
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      mem_wdata = d_wdata;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Next response owner and starvation count.
  always_comb begin
    state_d      = IDLE;
    starve_cnt_d = starve_cnt_q;
    if (if_gnt && !if_flush) begin
      state_d = RESP_IF;
    end else if (d_gnt && !d_we) begin
      state_d = RESP_LD;
    end else begin
      state_d = IDLE;
    end
    if (if_gnt || !if_req) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (d_gnt && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Response routing; a flush in the response cycle still kills fetch data.
  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (state_q)
      RESP_IF: if_rvalid = ~if_flush & ~rst;
      RESP_LD: d_rvalid  = ~rst;
      IDLE:    if_rvalid = 1'b0;
      default: d_rvalid  = 1'b0;
    endcase
    if (rst) begin
      if_rdata = {DATA_W{1'b0}};
      d_rdata  = {DATA_W{1'b0}};
    end else begin
      if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
      d_rdata  = d_rvalid  ? mem_rdata : d_rdata_q;
    end
  end

  // Response state, starvation counter and last-delivered data per port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= {CNT_W{1'b0}};
      if_rdata_q   <= {DATA_W{1'b0}};
      d_rdata_q    <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata;
      d_rdata_q    <= d_rdata;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_if_stall_q, perf_d_grant_q;

  // Saturating stall and data-grant event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_stall_q <= 16'h0000;
      perf_d_grant_q  <= 16'h0000;
    end else begin
      if (if_stall && (perf_if_stall_q != 16'hFFFF)) begin
        perf_if_stall_q <= perf_if_stall_q + 16'd1;
      end else begin
        perf_if_stall_q <= perf_if_stall_q;
      end
      if (d_gnt && (perf_d_grant_q != 16'hFFFF)) begin
        perf_d_grant_q <= perf_d_grant_q + 16'd1;
      end else begin
        perf_d_grant_q <= perf_d_grant_q;
      end
    end
  end

  assign perf_if_stall = perf_if_stall_q;
  assign perf_d_grant  = perf_d_grant_q;
`else
  assign perf_if_stall = 16'h0000;
  assign perf_d_grant  = 16'h0000;
`endif

endmodule
